carry_status_combine: RTL and testbench
=======================================

Name: carry_status_combine

Overview:
- Registered, lane-parallel prefix operator for a parallel-prefix (Kogge-Stone style) carry network in the floating-point adder datapath.
- Each lane merges a 2-bit carry status from a lower-order position (prev) with the status of the current position (cur).
- The merged status feeds the next prefix level.
- One instance handles LANES independent merges per cycle, with one cycle of latency.

Parameters:
- LANES, 17, number of independent combine lanes (17 = one prefix level of the 16-bit mantissa path plus carry-in).
- STW, 2, width of one carry-status code; fixed at 2, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- prev_i  input  LANES*STW  lower-order status per lane; lane k occupies bits [2k+1:2k]
- cur_i  input  LANES*STW  current-position status per lane, same packing
- out_o  output  LANES*STW  registered merged status per lane
- carry_o  output  LANES  registered resolved carry per lane; 1 when the lane result is GENERATE
- resolved_o  output  LANES  registered per-lane flag; 1 when the lane result is KILL or GENERATE
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Status encoding:
  - 2'b00 = KILL (carry 0).
  - 2'b11 = GENERATE (carry 1).
  - 2'b01 = PROPAGATE.
  - 2'b10 is also accepted as PROPAGATE on input.
- Per-lane combine rule, result r:
  - cur is KILL -> r = 2'b00.
  - cur is GENERATE -> r = 2'b11.
  - cur is PROPAGATE (01 or 10) -> r = prev, passed bit-exact including 2'b10.
- Derived flags: carry_o[k] = (r == 2'b11); resolved_o[k] = (r == 2'b00) || (r == 2'b11).
- Lanes are fully independent; no cross-lane logic.
- Latency:
  - Exactly 1 cycle: on each rising clk, out_o, carry_o, resolved_o and out_valid capture the values computed from the current inputs.
  - When in_valid = 0 the data registers hold their previous values and out_valid drops to 0 on that edge.
- No backpressure, no handshake beyond valid; a new operand set is accepted every cycle.
- Reset: rst_n low asynchronously forces out_o to all 2'b00 (KILL in every lane), carry_o = 0, resolved_o = all 1s, out_valid = 0.
- Reset wins over a simultaneous clock edge. Release is synchronous to the next clk edge with rst_n high.
- Reset asserted mid-stream discards any in-flight result. The first valid output after release is the first in_valid captured after release.
- X-free requirement: all outputs are driven from flops only; no combinational input-to-output path.

Decomposition:
- Shared package carry_pkg:
  - typedef status_t (2-bit).
  - Constants ST_KILL = 2'b00, ST_PROP = 2'b01, ST_PROP_ALT = 2'b10, ST_GEN = 2'b11.
  - Function is_prop(status_t).
- One natural sub-module: carry_status_cell, the purely combinational single-lane merge (prev, cur -> r, carry, resolved). It is instantiated LANES times by a generate loop. The top level holds only the registers and valid path.

Test Plan:
- Reset: hold rst_n = 0 with random inputs and clock running -> out_o = 0, carry_o = 0, resolved_o = 17'h1FFFF, out_valid = 0. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Truth table: lane 0 sweeps all 16 (prev, cur) pairs with in_valid = 1. Next cycle:
  - cur = 00 -> out 00, carry 0, resolved 1.
  - cur = 11 -> out 11, carry 1, resolved 1.
  - cur = 01 or 10 -> out = prev; e.g. prev = 11, cur = 01 -> out 11, carry 1.
- Lane independence: prev_i all 11, cur_i alternating 01/00 per lane -> out_o alternates 11/00, carry_o = 17'h15555 (even lanes 1).
- Hold: in_valid = 1 with cur_i all 11, then in_valid = 0 with cur_i all 00 -> out_o stays all 11, out_valid goes 1 then 0.
- Propagate alias: prev = 10, cur = 01 -> out_o lane = 2'b10, carry 0, resolved 0.
- Back-to-back streaming: 20 consecutive random valid vectors -> each output equals the golden model of the vector applied one cycle earlier, with no bubbles.

Source files
------------

// File: rtl/carry_pkg.sv
// Shared carry-status encoding for the parallel-prefix carry network.
// Status codes, the status type and small classification helpers.
package carry_pkg;

   localparam int STATUS_W = 2;

   typedef logic [STATUS_W-1:0] status_t;

   localparam status_t ST_KILL     = 2'b00;
   localparam status_t ST_PROP     = 2'b01;
   localparam status_t ST_PROP_ALT = 2'b10;
   localparam status_t ST_GEN      = 2'b11;

   // Both mixed codes mean "pass the lower-order status through".
   function automatic logic is_prop(status_t s);
      return (s == ST_PROP) || (s == ST_PROP_ALT);
   endfunction

   function automatic logic is_resolved(status_t s);
      return (s == ST_KILL) || (s == ST_GEN);
   endfunction

endpackage

// File: rtl/carry_status_cell.sv
// Single-lane prefix operator: merges lower-order status prev with current status cur.
// Purely combinational; the enclosing block registers the results.
module carry_status_cell
   import carry_pkg::*;
(
   input  logic [1:0] prev,
   input  logic [1:0] cur,
   output logic [1:0] r,
   output logic       carry,
   output logic       resolved
);

   status_t r_st;

   always_comb begin
      // NOTE: default assigned first so every path drives r_st and no latch is inferred.
      r_st = ST_KILL;
      if (cur == ST_GEN) begin
         r_st = ST_GEN;
      end else if (is_prop(cur)) begin
         r_st = prev;
      end
   end

   assign r        = r_st;
   assign carry    = (r_st == ST_GEN);
   assign resolved = is_resolved(r_st);

endmodule

// File: rtl/carry_status_combine.sv
// Registered, lane-parallel carry-status combine: one prefix level of the FP adder carry tree.
// LANES independent merges per cycle, one cycle latency, outputs driven only from flops.
module carry_status_combine
   import carry_pkg::*;
#(
   parameter int LANES = 17,
   parameter int STW   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [LANES*STW-1:0]   prev_i,
   input  logic [LANES*STW-1:0]   cur_i,
   output logic [LANES*STW-1:0]   out_o,
   output logic [LANES-1:0]       carry_o,
   output logic [LANES-1:0]       resolved_o,
   output logic                   out_valid
);

   logic [LANES*STW-1:0] r_comb;
   logic [LANES-1:0]     carry_comb;
   logic [LANES-1:0]     resolved_comb;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      carry_status_cell u_cell (
         .prev     (prev_i[STW*k +: STW]),
         .cur      (cur_i[STW*k +: STW]),
         .r        (r_comb[STW*k +: STW]),
         .carry    (carry_comb[k]),
         .resolved (resolved_comb[k])
      );
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_o      <= '0;
         carry_o    <= '0;
         resolved_o <= '1;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         // Data holds its last value across invalid cycles; only the valid flag drops.
         if (in_valid) begin
            out_o      <= r_comb;
            carry_o    <= carry_comb;
            resolved_o <= resolved_comb;
         end
      end
   end

endmodule

// File: tb/tb_carry_status_combine.sv
// Self-checking bench for carry_status_combine: directed cases plus random streaming
// against a lane-by-lane reference model of the combine rule.
module tb_carry_status_combine;

   localparam int LANES = 17;
   localparam int W     = LANES * 2;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic [W-1:0]   prev_i;
   logic [W-1:0]   cur_i;
   logic [W-1:0]   out_o;
   logic [LANES-1:0] carry_o;
   logic [LANES-1:0] resolved_o;
   logic           out_valid;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]     exp_out;
   logic [LANES-1:0] exp_carry;
   logic [LANES-1:0] exp_res;
   logic             exp_valid;

   carry_status_combine #(.LANES(LANES), .STW(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .prev_i     (prev_i),
      .cur_i      (cur_i),
      .out_o      (out_o),
      .carry_o    (carry_o),
      .resolved_o (resolved_o),
      .out_valid  (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: a killed lane yields 0, a generated lane yields 3, anything else copies prev.
   function automatic int lane_result(input int p, input int c);
      if (c == 0) return 0;
      if (c == 3) return 3;
      return p;
   endfunction

   task automatic model_capture(input logic [W-1:0] p, input logic [W-1:0] c);
      for (int k = 0; k < LANES; k++) begin
         int r;
         r = lane_result(int'(p[2*k +: 2]), int'(c[2*k +: 2]));
         exp_out[2*k +: 2] = 2'(r);
         exp_carry[k]      = (r == 3);
         exp_res[k]        = (r == 0) || (r == 3);
      end
   endtask

   task automatic model_reset();
      exp_out   = '0;
      exp_carry = '0;
      exp_res   = '1;
      exp_valid = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},      64'(out_o),      64'(exp_out));
      check({tag, ".carry"},    64'(carry_o),    64'(exp_carry));
      check({tag, ".resolved"}, 64'(resolved_o), 64'(exp_res));
      check({tag, ".valid"},    64'(out_valid),  64'(exp_valid));
   endtask

   // Drive one operand set, let the edge capture it, then compare #1 later.
   task automatic step(input string tag, input logic v, input logic [W-1:0] p, input logic [W-1:0] c);
      in_valid = v;
      prev_i   = p;
      cur_i    = c;
      @(posedge clk);
      exp_valid = v;
      if (v) model_capture(p, c);
      #1;
      check_all(tag);
   endtask

   function automatic logic [W-1:0] rand_vec();
      return W'({$urandom, $urandom});
   endfunction

   function automatic logic [W-1:0] replicate(input logic [1:0] s);
      logic [W-1:0] v;
      for (int k = 0; k < LANES; k++) v[2*k +: 2] = s;
      return v;
   endfunction

   initial begin
      logic [W-1:0] p;
      logic [W-1:0] c;

      model_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      prev_i   = rand_vec();
      cur_i    = rand_vec();

      // Held in reset with random, valid inputs and a running clock.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         prev_i = rand_vec();
         cur_i  = rand_vec();
      end
      #1;
      check("rst.out",      64'(out_o),      64'h0);
      check("rst.carry",    64'(carry_o),    64'h0);
      check("rst.resolved", 64'(resolved_o), 64'h1FFFF);
      check("rst.valid",    64'(out_valid),  64'h0);

      @(negedge clk);
      rst_n = 1'b1;

      // Lane 0 sweeps all 16 (prev, cur) pairs; other lanes random.
      for (int pv = 0; pv < 4; pv++) begin
         for (int cv = 0; cv < 4; cv++) begin
            p = rand_vec();
            c = rand_vec();
            p[1:0] = 2'(pv);
            c[1:0] = 2'(cv);
            step($sformatf("tt.p%0d.c%0d", pv, cv), 1'b1, p, c);
         end
      end

      // Explicit lane-0 cases with literal expectations.
      p = '0; c = '0;
      p[1:0] = 2'b11; c[1:0] = 2'b01;
      step("gen_through_prop", 1'b1, p, c);
      check("gen_through_prop.lane0", 64'(out_o[1:0]), 64'h3);
      check("gen_through_prop.carry0", 64'(carry_o[0]), 64'h1);

      p[1:0] = 2'b10; c[1:0] = 2'b01;
      step("prop_alias", 1'b1, p, c);
      check("prop_alias.lane0", 64'(out_o[1:0]), 64'h2);
      check("prop_alias.carry0", 64'(carry_o[0]), 64'h0);
      check("prop_alias.res0", 64'(resolved_o[0]), 64'h0);

      // Lane independence: even lanes propagate a generate, odd lanes kill.
      p = replicate(2'b11);
      for (int k = 0; k < LANES; k++) c[2*k +: 2] = (k % 2 == 0) ? 2'b01 : 2'b00;
      step("indep", 1'b1, p, c);
      check("indep.carry", 64'(carry_o), 64'h15555);

      // Hold: invalid cycle must not disturb the data registers.
      step("hold.load", 1'b1, rand_vec(), replicate(2'b11));
      check("hold.load.out", 64'(out_o), 64'h3_FFFF_FFFF);
      step("hold.idle", 1'b0, rand_vec(), replicate(2'b00));
      check("hold.idle.out", 64'(out_o), 64'h3_FFFF_FFFF);
      check("hold.idle.valid", 64'(out_valid), 64'h0);

      // Asynchronous reset between edges clears outputs immediately.
      step("pre_async", 1'b1, replicate(2'b11), replicate(2'b11));
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst.idle", 1'b0, rand_vec(), replicate(2'b11));
      step("post_rst.first", 1'b1, rand_vec(), rand_vec());

      // Back-to-back random streaming, no bubbles.
      for (int i = 0; i < 20; i++) begin
         step($sformatf("stream%0d", i), 1'b1, rand_vec(), rand_vec());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
